// File: rtl/mem_seq_if.sv
// Control, external-memory and output-sample bundle for mem_seq_player.
// The slave modport is the player's view; master is the driver/memory side.
interface mem_seq_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9
);
  localparam int unsigned CNT_W = 8;

  logic              ce;
  logic              start;
  logic              stop;
  logic              mode_loop;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic [CNT_W-1:0]  loop_cnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rden;
  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] Q;
  logic              q_valid;
  logic              q_last;
  logic              busy;
  logic              done;

  modport master (
    output ce, start, stop, mode_loop, start_addr, end_addr, loop_cnt, mem_q,
    input  mem_addr, mem_rden, Q, q_valid, q_last, busy, done
  );

  modport slave (
    input  ce, start, stop, mode_loop, start_addr, end_addr, loop_cnt, mem_q,
    output mem_addr, mem_rden, Q, q_valid, q_last, busy, done
  );
endinterface

// File: rtl/mem_seq_player.sv
// Plays an address range out of an external synchronous memory, one-shot or
// looped, and re-times the returned words onto a registered output sample.
module mem_seq_player #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  mem_seq_if.slave bus
);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  addr, addr_nx;
  logic [ADDR_W-1:0]  lo_r, hi_r;
  logic               loop_r;
  logic [CNT_W-1:0]   lcnt_r;
  logic [CNT_W-1:0]   pass_r, pass_nx;
  logic               rden_c;
  logic               final_c;
  logic               done_nx;
  logic [MEM_LAT-1:0] vpipe;
  logic [MEM_LAT-1:0] lpipe;
  logic [DATA_W-1:0]  q_r;
  logic               q_valid_r;
  logic               q_last_r;
  logic               done_r;

  // Next-state, address sequencing and read strobe.
  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    pass_nx  = pass_r;
    rden_c   = 1'b0;
    final_c  = 1'b0;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = RUN;
          addr_nx  = bus.start_addr;
          pass_nx  = CNT_W'(1);
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nx = DRAIN;
        end else if (bus.ce) begin
          rden_c = 1'b1;
          if (addr == hi_r) begin
            // Final word: one-shot, or last of a finite number of passes.
            if (!loop_r || (lcnt_r != '0 && pass_r == lcnt_r)) begin
              final_c  = 1'b1;
              state_nx = DRAIN;
            end else begin
              addr_nx = lo_r;
              pass_nx = pass_r + CNT_W'(1);
            end
          end else begin
            addr_nx = addr + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        // Remaining word (if any) lands on q_valid this edge; done follows it.
        if (vpipe == '0) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, sequence parameters and the read-return pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      pass_r    <= '0;
      lo_r      <= '0;
      hi_r      <= '0;
      loop_r    <= 1'b0;
      lcnt_r    <= '0;
      vpipe     <= '0;
      lpipe     <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      q_last_r  <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state  <= state_nx;
      addr   <= addr_nx;
      pass_r <= pass_nx;
      if (state == IDLE && bus.start) begin
        lo_r   <= bus.start_addr;
        hi_r   <= bus.end_addr;
        loop_r <= bus.mode_loop;
        lcnt_r <= bus.loop_cnt;
      end
      vpipe     <= MEM_LAT'({vpipe, rden_c});
      lpipe     <= MEM_LAT'({lpipe, final_c});
      q_valid_r <= vpipe[MEM_LAT-1];
      q_last_r  <= vpipe[MEM_LAT-1] & lpipe[MEM_LAT-1];
      if (vpipe[MEM_LAT-1]) begin
        q_r <= bus.mem_q;
      end
      done_r <= done_nx;
    end
  end

  assign bus.mem_addr = addr;
  assign bus.mem_rden = rden_c;
  assign bus.Q        = q_r;
  assign bus.q_valid  = q_valid_r;
  assign bus.q_last   = q_last_r;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_r;
endmodule
